cruise_speed_controller: RTL and testbench
==========================================

CRUISE_SPEED_CONTROLLER -- requirements
Module: cruise_speed_controller

Interface
REQ-001 The block SHALL have parameter MIN_SPEED, default 8'd40, lowest speed at which cruise may engage.
REQ-002 The block SHALL have parameter MAX_SPEED, default 8'd200, highest allowed target speed.
REQ-003 The block SHALL have parameter RATE_DIV, default 16, clock cycles per ±1 target step while accel/coast is held (≥2).
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- speed  in  8  current vehicle speed, unsigned.
- cmp_g / cmp_eq / cmp_l  in  1 each  comparator result for a=speed, b=target_speed (speed >, =, < target).
- btn_on, btn_off, btn_set, btn_accel, btn_coast, brake  in  1 each  level inputs, already synchronised and debounced.
- btn_resume  in  1  present only when CRUISE_RESUME_EN is defined.
- target_speed  out  8  registered set-point; drives comparator input b.
- throttle_up, throttle_down  out  1 each  registered drive requests.
- cruise_active  out  1  high in state CRUISE.
- state_o  out  2  current FSM state encoding.

Function
REQ-005 The FSM SHALL have states OFF=0, STANDBY=1, CRUISE=2 and SUSPENDED=3.
REQ-006 Each cycle SHALL apply the first matching event in this order: btn_off, brake, btn_set, btn_resume, accel/coast.
REQ-007 In any state, btn_off SHALL cause a transition to OFF and clear target_speed to 0.
REQ-008 In OFF, btn_on SHALL cause a transition to STANDBY; all other inputs SHALL be ignored.
REQ-009 In STANDBY or CRUISE, btn_set with MIN_SPEED ≤ speed ≤ MAX_SPEED SHALL load target_speed←speed and enter CRUISE; with speed out of range, btn_set SHALL be ignored.
REQ-010 In CRUISE, brake SHALL leave CRUISE on the next edge: to SUSPENDED when CRUISE_RESUME_EN is defined, otherwise to STANDBY.
REQ-011 In CRUISE, btn_accel alone SHALL add 1 to target_speed on the first cycle it is held and then every RATE_DIV cycles while held, saturating at MAX_SPEED.
REQ-012 In CRUISE, btn_coast alone SHALL subtract 1 from target_speed with the same timing as accel, saturating at MIN_SPEED.
REQ-013 With btn_accel and btn_coast both high, target_speed SHALL not change and the rate counter SHALL clear.
REQ-014 The rate counter SHALL clear whenever neither button is held or the state is not CRUISE.
REQ-015 In CRUISE, throttle_up SHALL equal the registered cmp_l and throttle_down SHALL equal the registered cmp_g, a latency of one cycle.
REQ-016 Outside CRUISE, throttle_up and throttle_down SHALL be 0 on the edge the state is left, and SHALL stay 0.
REQ-017 throttle_up and throttle_down SHALL never be high together; if cmp_g and cmp_l are both asserted, both outputs SHALL be 0.
REQ-018 Arithmetic on target_speed SHALL be unsigned 8-bit and clamped, with no wrap-around.
REQ-019 On entry to STANDBY from CRUISE, target_speed SHALL hold its value.

Reset
REQ-020 When rst_n=0 at a clock edge, the block SHALL set state=OFF, target_speed=0, throttle_up=0, throttle_down=0, cruise_active=0 and rate counter=0, including mid-ramp.
REQ-021 No output SHALL change asynchronously to clk.

Configuration
REQ-022 When CRUISE_RESUME_EN is defined, the block SHALL include the SUSPENDED state and the btn_resume port:
- In SUSPENDED, btn_resume with speed ≥ MIN_SPEED and target_speed ≠ 0 SHALL enter CRUISE with target_speed unchanged.
- In SUSPENDED, btn_set SHALL behave as in REQ-009.
- In SUSPENDED, brake SHALL be ignored.
REQ-023 When CRUISE_RESUME_EN is undefined, the block SHALL omit btn_resume and make encoding 3 unreachable; the FSM SHALL recover from encoding 3 to OFF.

Structure
REQ-024 A shared package cruise_pkg SHALL hold the state typedef/encodings and default speed limits.
REQ-025 The rate counter with its step strobe SHALL be one sub-module, cruise_rate_timer.

Verification
REQ-026 The bench SHALL cover the following scenarios:
- Reset, then btn_on, then btn_set with speed=60: CRUISE, target_speed=60, cruise_active=1.
- btn_set with speed=30: stays STANDBY, target_speed=0.
- btn_accel held 3·RATE_DIV cycles from target 198 with MAX=200: target sequence 199, 200, 200.
- CRUISE target 60, speed 55 (cmp_l=1): throttle_up=1 one cycle later; brake asserted: both throttles 0 next edge; with CRUISE_RESUME_EN, btn_resume returns CRUISE at target 60.
- btn_accel and btn_coast both high: target unchanged; brake and btn_set together: brake wins.
- rst_n low during accel ramp: all outputs 0, state OFF next edge.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared state encodings, default speed limits and the clamped target-step helper
// for the cruise speed controller.
package cruise_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_STANDBY   = 2'd1,
        ST_CRUISE    = 2'd2,
        ST_SUSPENDED = 2'd3
    } cruise_state_e;

    localparam logic [7:0] DEF_MIN_SPEED = 8'd40;
    localparam logic [7:0] DEF_MAX_SPEED = 8'd200;
    localparam int         DEF_RATE_DIV  = 16;

    // One +/-1 step of the set-point, clamped to [lo, hi] so it never wraps.
    function automatic logic [7:0] step_target(input logic [7:0] cur, input logic up,
                                               input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] res;
        if (up) begin
            if (cur >= hi) res = hi;
            else           res = cur + 8'd1;
        end else begin
            if (cur <= lo) res = lo;
            else           res = cur - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cruise_rate_timer.sv
// Accel/coast repeat timer: strobes step on the first held cycle and then every
// RATE_DIV cycles while hold stays high; clears whenever hold drops.
module cruise_rate_timer
    import cruise_pkg::*;
#(
    parameter int RATE_DIV = DEF_RATE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic step
);

    localparam int              CNT_W    = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at RATE_DIV-1 while held, otherwise restart from zero.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (hold) begin
            if (cnt_q == CNT_LAST) cnt_d = {CNT_W{1'b0}};
            else                   cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= {CNT_W{1'b0}};
        else        cnt_q <= cnt_d;
    end

    assign step = hold && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/cruise_speed_controller.sv
// Cruise speed controller: OFF/STANDBY/CRUISE FSM with set-point ramping and
// registered throttle requests. Define CRUISE_RESUME_EN to add SUSPENDED and btn_resume.
module cruise_speed_controller
    import cruise_pkg::*;
#(
    parameter logic [7:0] MIN_SPEED = DEF_MIN_SPEED,
    parameter logic [7:0] MAX_SPEED = DEF_MAX_SPEED,
    parameter int         RATE_DIV  = DEF_RATE_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] speed,
    input  logic       cmp_g,
    input  logic       cmp_eq,
    input  logic       cmp_l,
    input  logic       btn_on,
    input  logic       btn_off,
    input  logic       btn_set,
    input  logic       btn_accel,
    input  logic       btn_coast,
    input  logic       brake,
`ifdef CRUISE_RESUME_EN
    input  logic       btn_resume,
`endif
    output logic [7:0] target_speed,
    output logic       throttle_up,
    output logic       throttle_down,
    output logic       cruise_active,
    output logic [1:0] state_o
);

    cruise_state_e state_q, state_d;
    logic [7:0]    target_q, target_d;
    logic          throttle_up_q, throttle_up_d;
    logic          throttle_down_q, throttle_down_d;
    logic          cruise_active_q, cruise_active_d;

    logic          set_ok_s;
    logic          ramp_hold_s;
    logic          rate_step_s;
    logic          unused_s;

    // Equality is implied by the other two comparator lines and is not needed.
    assign unused_s = cmp_eq;

    assign set_ok_s = btn_set && (speed >= MIN_SPEED) && (speed <= MAX_SPEED);

    // Ramping only when accel/coast is the event actually applied this cycle.
    assign ramp_hold_s = (state_q == ST_CRUISE) && !btn_off && !brake && !set_ok_s
                         && (btn_accel ^ btn_coast);

    cruise_rate_timer #(
        .RATE_DIV (RATE_DIV)
    ) u_rate_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (ramp_hold_s),
        .step  (rate_step_s)
    );

    // State and set-point register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_OFF;
            target_q        <= 8'd0;
            throttle_up_q   <= 1'b0;
            throttle_down_q <= 1'b0;
            cruise_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            throttle_up_q   <= throttle_up_d;
            throttle_down_q <= throttle_down_d;
            cruise_active_q <= cruise_active_d;
        end
    end

    // Next state and set-point, events applied in priority order.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (btn_off) begin
            state_d  = ST_OFF;
            target_d = 8'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (btn_on) state_d = ST_STANDBY;
                    else        state_d = ST_OFF;
                end
                ST_STANDBY: begin
                    if (brake) begin
                        state_d = ST_STANDBY;
                    end else if (set_ok_s) begin
                        state_d  = ST_CRUISE;
                        target_d = speed;
                    end else begin
                        state_d = ST_STANDBY;
                    end
                end
                ST_CRUISE: begin
                    if (brake) begin
`ifdef CRUISE_RESUME_EN
                        state_d = ST_SUSPENDED;
`else
                        state_d = ST_STANDBY;
`endif
                    end else if (set_ok_s) begin
                        target_d = speed;
                    end else if (ramp_hold_s && rate_step_s) begin
                        target_d = step_target(target_q, btn_accel, MIN_SPEED, MAX_SPEED);
                    end else begin
                        target_d = target_q;
                    end
                end
                ST_SUSPENDED: begin
`ifdef CRUISE_RESUME_EN
                    if (set_ok_s) begin
                        state_d  = ST_CRUISE;
                        target_d = speed;
                    end else if (btn_resume && (speed >= MIN_SPEED) && (target_q != 8'd0)) begin
                        state_d = ST_CRUISE;
                    end else begin
                        state_d = ST_SUSPENDED;
                    end
`else
                    state_d  = ST_OFF;
                    target_d = 8'd0;
`endif
                end
                default: begin
                    state_d  = ST_OFF;
                    target_d = 8'd0;
                end
            endcase
        end
    end

    // Registered outputs follow the state being entered; conflicting comparator drives nothing.
    always_comb begin
        cruise_active_d = (state_d == ST_CRUISE);
        if ((state_d == ST_CRUISE) && !(cmp_g && cmp_l)) begin
            throttle_up_d   = cmp_l;
            throttle_down_d = cmp_g;
        end else begin
            throttle_up_d   = 1'b0;
            throttle_down_d = 1'b0;
        end
    end

    assign target_speed  = target_q;
    assign throttle_up   = throttle_up_q;
    assign throttle_down = throttle_down_q;
    assign cruise_active = cruise_active_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Bench for cruise_speed_controller: directed scenarios then randomized traffic,
// all checked against a rule-level reference model (honours CRUISE_RESUME_EN).
module tb_cruise_speed_controller;

    localparam logic [7:0] MIN_SPEED = 8'd40;
    localparam logic [7:0] MAX_SPEED = 8'd200;
    localparam int         RATE_DIV  = 5;
`ifdef CRUISE_RESUME_EN
    localparam bit         RESUME    = 1'b1;
`else
    localparam bit         RESUME    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] speed;
    logic       cmp_g, cmp_eq, cmp_l;
    logic       btn_on, btn_off, btn_set, btn_accel, btn_coast, brake, btn_resume;
    logic [7:0] target_speed;
    logic       throttle_up, throttle_down, cruise_active;
    logic [1:0] state_o;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  cmp_rand = 1'b0;

    // Reference model state.
    int         m_state;
    int         m_target;
    int         m_run;
    bit         m_up, m_down, m_active;

    always #5 clk = ~clk;

    cruise_speed_controller #(
        .MIN_SPEED (MIN_SPEED),
        .MAX_SPEED (MAX_SPEED),
        .RATE_DIV  (RATE_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .speed         (speed),
        .cmp_g         (cmp_g),
        .cmp_eq        (cmp_eq),
        .cmp_l         (cmp_l),
        .btn_on        (btn_on),
        .btn_off       (btn_off),
        .btn_set       (btn_set),
        .btn_accel     (btn_accel),
        .btn_coast     (btn_coast),
        .brake         (brake),
`ifdef CRUISE_RESUME_EN
        .btn_resume    (btn_resume),
`endif
        .target_speed  (target_speed),
        .throttle_up   (throttle_up),
        .throttle_down (throttle_down),
        .cruise_active (cruise_active),
        .state_o       (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies one clock's worth of the written rules to the model.
    task automatic model_step();
        int  ns;
        int  nt;
        bit  ramping;
        bit  set_ok;
        ns      = m_state;
        nt      = m_target;
        ramping = 1'b0;
        set_ok  = btn_set && (speed >= MIN_SPEED) && (speed <= MAX_SPEED);
        if (!rst_n) begin
            ns = 0;
            nt = 0;
        end else if (btn_off) begin
            ns = 0;
            nt = 0;
        end else begin
            case (m_state)
                0: if (btn_on) ns = 1;
                1: if (!brake && set_ok) begin ns = 2; nt = speed; end
                2: begin
                    if (brake) ns = RESUME ? 3 : 1;
                    else if (set_ok) nt = speed;
                    else if (btn_accel != btn_coast) begin
                        ramping = 1'b1;
                        if (m_run % RATE_DIV == 0) begin
                            if (btn_accel) nt = (m_target >= MAX_SPEED) ? MAX_SPEED : m_target + 1;
                            else           nt = (m_target <= MIN_SPEED) ? MIN_SPEED : m_target - 1;
                        end
                    end
                end
                3: begin
                    if (set_ok) begin ns = 2; nt = speed; end
                    else if (btn_resume && speed >= MIN_SPEED && m_target != 0) ns = 2;
                end
                default: begin ns = 0; nt = 0; end
            endcase
        end
        m_run    = (rst_n && ramping) ? m_run + 1 : 0;
        m_active = rst_n && (ns == 2);
        m_up     = m_active && cmp_l && !cmp_g;
        m_down   = m_active && cmp_g && !cmp_l;
        m_state  = ns;
        m_target = nt;
    endtask

    task automatic check_all();
        check_val("state",    32'(state_o),       32'(m_state));
        check_val("target",   32'(target_speed),  32'(m_target));
        check_val("thr_up",   32'(throttle_up),   32'(m_up));
        check_val("thr_down", 32'(throttle_down), 32'(m_down));
        check_val("active",   32'(cruise_active), 32'(m_active));
    endtask

    // One clock: comparator follows the model set-point unless deliberately scrambled.
    task automatic tick();
        if (!cmp_rand) begin
            cmp_g  = (int'(speed) >  m_target);
            cmp_eq = (int'(speed) == m_target);
            cmp_l  = (int'(speed) <  m_target);
        end
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic clear_btns();
        btn_on = 1'b0; btn_off = 1'b0; btn_set = 1'b0; btn_accel = 1'b0;
        btn_coast = 1'b0; brake = 1'b0; btn_resume = 1'b0;
    endtask

    task automatic engage(input logic [7:0] spd);
        speed = spd; btn_set = 1'b1; tick(); btn_set = 1'b0;
    endtask

    initial begin
        m_state = 0; m_target = 0; m_run = 0;
        m_up = 1'b0; m_down = 1'b0; m_active = 1'b0;
        clear_btns();
        speed = 8'd0;
        rst_n = 1'b0;
        tick();
        tick();
        check_val("rst_state", 32'(state_o), 32'd0);
        check_val("rst_target", 32'(target_speed), 32'd0);
        rst_n = 1'b1;

        btn_on = 1'b1; tick(); btn_on = 1'b0;
        check_val("on_standby", 32'(state_o), 32'd1);

        engage(8'd30);
        check_val("set30_state", 32'(state_o), 32'd1);
        check_val("set30_target", 32'(target_speed), 32'd0);

        engage(8'd60);
        check_val("set60_state", 32'(state_o), 32'd2);
        check_val("set60_target", 32'(target_speed), 32'd60);
        check_val("set60_active", 32'(cruise_active), 32'd1);

        speed = 8'd55; tick();
        check_val("thr_up_lat", 32'(throttle_up), 32'd1);

        // Brake together with a valid set: brake must win.
        brake = 1'b1; btn_set = 1'b1; tick(); brake = 1'b0; btn_set = 1'b0;
        check_val("brake_state", 32'(state_o), RESUME ? 32'd3 : 32'd1);
        check_val("brake_thr", 32'({throttle_up, throttle_down}), 32'd0);
        check_val("brake_target", 32'(target_speed), 32'd60);
        tick();
        check_val("brake_thr_hold", 32'({throttle_up, throttle_down}), 32'd0);

        if (RESUME) begin
            btn_resume = 1'b1; tick(); btn_resume = 1'b0;
        end else begin
            engage(8'd60);
        end
        check_val("resume_state", 32'(state_o), 32'd2);
        check_val("resume_target", 32'(target_speed), 32'd60);

        btn_accel = 1'b1; btn_coast = 1'b1;
        for (int i = 0; i < 2 * RATE_DIV; i++) tick();
        clear_btns();
        check_val("both_target", 32'(target_speed), 32'd60);

        engage(8'd198);
        btn_accel = 1'b1;
        for (int i = 0; i < 3 * RATE_DIV; i++) begin
            tick();
            if (i == 0)            check_val("ramp_1", 32'(target_speed), 32'd199);
            if (i == RATE_DIV)     check_val("ramp_2", 32'(target_speed), 32'd200);
            if (i == 2 * RATE_DIV) check_val("ramp_3", 32'(target_speed), 32'd200);
        end
        btn_accel = 1'b0;

        engage(8'd41);
        btn_coast = 1'b1;
        for (int i = 0; i < 2 * RATE_DIV + 1; i++) tick();
        btn_coast = 1'b0;
        check_val("coast_floor", 32'(target_speed), 32'd40);

        engage(8'd100);
        btn_accel = 1'b1;
        for (int i = 0; i < RATE_DIV + 2; i++) tick();
        rst_n = 1'b0; tick();
        check_val("rst_ramp_state", 32'(state_o), 32'd0);
        check_val("rst_ramp_outs",
                  32'({target_speed, throttle_up, throttle_down, cruise_active}), 32'd0);
        rst_n = 1'b1; btn_accel = 1'b0;

        // Randomized traffic with sticky accel/coast so ramps actually develop.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            btn_off   = ($urandom_range(0, 79) == 0);
            btn_on    = ($urandom_range(0, 7) == 0);
            btn_set   = ($urandom_range(0, 15) == 0);
            brake     = ($urandom_range(0, 39) == 0);
            btn_resume = RESUME && ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) btn_accel = ~btn_accel;
            if ($urandom_range(0, 19) == 0) btn_coast = ~btn_coast;
            if ($urandom_range(0, 7) == 0) speed = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) speed = 8'($urandom_range(30, 210));
            cmp_rand = ($urandom_range(0, 15) == 0);
            if (cmp_rand) begin
                cmp_g  = 1'($urandom_range(0, 1));
                cmp_eq = 1'($urandom_range(0, 1));
                cmp_l  = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
